uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_fifo.sv | 63 ++++++
 rtl/uart_tx.sv | 141 ++++++++++++++
 tb/tb_uart_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-period arithmetic and line FSM state encoding.
// Imported by the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Clocks per bit; integer division, so the real baud rate rounds up slightly.
  function automatic int calc_cycle(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small byte FIFO in front of the UART transmitter.
// Power-of-two depth; pointers wrap naturally, count is kept separately.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push,
  input  logic [7:0]                  i_din,
  input  logic                        i_pop,
  output logic [7:0]                  o_dout,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CNTW-1:0] r_count;

  logic w_wr;
  logic w_rd;

  assign o_full  = (r_count == CNTW'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];

  // Guarded here too, so the count can never run past either end.
  assign w_wr = i_push && !o_full;
  assign w_rd = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: FIFO front end, bit-timing FSM, shifter.
// The line register follows the FSM state by one clock.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BODE_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);

  localparam int CYCLE = calc_cycle(CLK_FREQ, BODE_RATE);
  localparam int CW    = $clog2(CYCLE);
  localparam int CNTW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLE - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t r_state;
  uart_state_t w_state_d;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;
  logic [CW-1:0] w_cnt_step;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_d;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_d;
  logic          r_tx;
  logic          w_tx_d;

  logic            w_last;
  logic            w_pop;
  logic            w_push;
  logic            w_full;
  logic            w_empty;
  logic [7:0]      w_head;
  logic [CNTW-1:0] w_count;

  assign w_push = tx_data_valid && !w_full;

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_din  (tx_data),
    .i_pop  (w_pop),
    .o_dout (w_head),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(w_count)
  );

  assign w_last     = (r_cnt == LAST);
  assign w_cnt_step = w_last ? '0 : r_cnt + 1'b1;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_idx_d   = r_idx;
    w_shift_d = r_shift;
    w_tx_d    = 1'b1;
    w_pop     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_d = '0;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_d = w_head;
          w_state_d = START;
        end
      end
      START: begin
        w_tx_d  = 1'b0;
        w_cnt_d = w_cnt_step;
        if (w_last) begin
          w_idx_d   = '0;
          w_state_d = DATA;
        end
      end
      DATA: begin
        w_tx_d  = r_shift[0];
        w_cnt_d = w_cnt_step;
        if (w_last) begin
          w_shift_d = r_shift >> 1;
          if (r_idx == LAST_BIT) begin
            w_idx_d   = '0;
            w_state_d = STOP;
          end else begin
            w_idx_d = r_idx + 1'b1;
          end
        end
      end
      STOP: begin
        w_cnt_d = w_cnt_step;
        if (w_last) begin
          // Chain straight into the next start bit when bytes are waiting.
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_shift_d = w_head;
            w_state_d = START;
          end else begin
            w_state_d = IDLE;
          end
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_idx   <= w_idx_d;
      r_shift <= w_shift_d;
      r_tx    <= w_tx_d;
    end
  end

  assign tx       = r_tx;
  assign tx_ready = !w_full;
  assign tx_busy  = (r_state != IDLE) || (w_count != '0);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CYCLE=8: vector table, corner sequences,
// and a line decoder that checks every frame against the pushed bytes.
module tb_uart_tx;

  localparam int CYC = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;

  int errors = 0;
  int checks = 0;
  int rx_cnt = 0;
  bit mon_en = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] pat;
    string      name;
  } vec_t;

  vec_t vecs[4];

  uart_tx #(
    .CLK_FREQ  (80),
    .BODE_RATE (10),
    .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_data_valid(tx_data_valid),
    .tx_ready     (tx_ready),
    .tx           (tx),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, output int waited);
    waited = 0;
    tx_data = d;
    tx_data_valid = 1'b1;
    while (!tx_ready && waited < 400) begin
      step();
      waited++;
    end
    if (!tx_ready) begin
      chk("push_ready_timeout", tx_ready, 1);
    end else begin
      step();
      exp_q.push_back(d);
    end
    tx_data_valid = 1'b0;
  endtask

  // Entered just after the edge where tx drops for the start bit.
  task automatic check_line(input logic [9:0] pat, input string nm);
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CYC; j++) begin
        if (j == 0 || j == CYC - 1) begin
          chk($sformatf("%s_bit%0d_c%0d", nm, k, j), tx, pat[9-k]);
        end
        step();
      end
    end
  endtask

  initial begin : monitor
    logic p;
    logic [7:0] b;
    p = 1'b1;
    forever begin
      step();
      if (mon_en && p === 1'b1 && tx === 1'b0) begin
        repeat (CYC / 2 - 1) @(posedge clk);
        #1;
        chk("rx_start_mid", tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CYC) @(posedge clk);
          #1;
          b[i] = tx;
        end
        repeat (CYC) @(posedge clk);
        #1;
        chk("rx_stop_mid", tx, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_extra: got byte %h, none outstanding", b);
        end else begin
          chk("rx_byte", b, exp_q.pop_front());
        end
        rx_cnt++;
      end
      p = tx;
    end
  end

  initial begin : main
    int w;
    int n;
    int viol_tx;
    int viol_rdy;
    int viol_busy;
    int rx0;

    vecs[0] = '{8'hA5, 10'b0101001011, "a5"};
    vecs[1] = '{8'h00, 10'b0000000001, "x00"};
    vecs[2] = '{8'hFF, 10'b0111111111, "xff"};
    vecs[3] = '{8'h3C, 10'b0001111001, "x3c"};

    rst = 1'b1;
    tx_data = '0;
    tx_data_valid = 1'b0;
    repeat (3) step();
    chk("rst_tx", tx, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    rst = 1'b0;

    viol_tx = 0;
    viol_rdy = 0;
    viol_busy = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tx !== 1'b1) viol_tx++;
      if (tx_ready !== 1'b1) viol_rdy++;
      if (tx_busy !== 1'b0) viol_busy++;
    end
    chk("idle_tx_bad_cycles", viol_tx, 0);
    chk("idle_ready_bad_cycles", viol_rdy, 0);
    chk("idle_busy_bad_cycles", viol_busy, 0);
    mon_en = 1'b1;

    for (int v = 0; v < 4; v++) begin
      push(vecs[v].data, w);
      chk({vecs[v].name, "_accept_tx"}, tx, 1);
      chk({vecs[v].name, "_accept_busy"}, tx_busy, 1);
      step();
      chk({vecs[v].name, "_edge1_tx"}, tx, 1);
      step();
      check_line(vecs[v].pat, vecs[v].name);
      chk({vecs[v].name, "_end_busy"}, tx_busy, 0);
      chk({vecs[v].name, "_end_tx"}, tx, 1);
      repeat (5) step();
    end

    push(8'hA5, w);
    step();
    n = 0;
    while (tx_busy && n < 300) begin
      n++;
      step();
    end
    chk("a5_busy_cycles_from_pop", n, 80);
    repeat (5) step();

    push(vecs[1].data, w);
    push(vecs[2].data, w);
    push(vecs[3].data, w);
    check_line(vecs[1].pat, "b2b_x00");
    check_line(vecs[2].pat, "b2b_xff");
    check_line(vecs[3].pat, "b2b_x3c");
    chk("b2b_end_busy", tx_busy, 0);
    chk("b2b_end_tx", tx, 1);
    repeat (5) step();

    rx0 = rx_cnt;
    for (int i = 0; i < 5; i++) begin
      push(8'h10 + 8'(i), w);
      chk($sformatf("ovf_push%0d_wait", i), w, 0);
    end
    chk("ovf_ready_low_when_full", tx_ready, 0);
    push(8'h15, w);
    chk("ovf_sixth_wait", w, 77);
    n = 0;
    while (tx_busy && n < 1000) begin
      n++;
      step();
    end
    chk("ovf_drain_busy", tx_busy, 0);
    chk("ovf_frames_received", rx_cnt - rx0, 6);
    chk("ovf_queue_empty", exp_q.size(), 0);
    repeat (5) step();

    mon_en = 1'b0;
    push(8'h81, w);
    push(8'h11, w);
    push(8'h22, w);
    chk("rst_mid_start_tx", tx, 0);
    repeat (33) step();
    chk("rst_mid_bit3_tx", tx, 0);
    chk("rst_mid_busy", tx_busy, 1);
    rst = 1'b1;
    step();
    chk("rst_mid_tx_high", tx, 1);
    chk("rst_mid_busy_low", tx_busy, 0);
    chk("rst_mid_ready", tx_ready, 1);
    rst = 1'b0;
    viol_tx = 0;
    viol_busy = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (tx !== 1'b1) viol_tx++;
      if (tx_busy !== 1'b0) viol_busy++;
    end
    chk("rst_after_tx_low_cycles", viol_tx, 0);
    chk("rst_after_busy_cycles", viol_busy, 0);
    exp_q.delete();
    mon_en = 1'b1;

    rx0 = rx_cnt;
    for (int i = 0; i < 256; i++) begin
      push(8'($urandom_range(0, 255)), w);
    end
    n = 0;
    while (tx_busy && n < 2000) begin
      n++;
      step();
    end
    chk("rand_drain_busy", tx_busy, 0);
    chk("rand_frames_received", rx_cnt - rx0, 256);
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
